// File: rtl/ppi_portc_watch.sv
// 8255 PPI port C shadow with per-channel programmable edge counters (arm/clear, timeout).
// Optional macro PPI_MODESET_EN: a mode-set control word clears the shadow like a real 8255.
module ppi_portc_watch #(
  parameter logic [7:0]             PPI_BASE    = 8'h00,
  parameter int                     NUM_WATCH   = 2,
  parameter logic [3*NUM_WATCH-1:0] WATCH_MAP   = 6'o31,
  parameter logic [NUM_WATCH-1:0]   EDGE_POL    = 2'b00,
  parameter int                     CNT_W       = 4,
  parameter int                     DONE_COUNT  = 4,
  parameter int                     TIMEOUT_CYC = 0,
  parameter logic [7:0]             PORTC_INIT  = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 shavv,
  input  logic [7:0]                 data,
  input  logic                       wr_stb,
  input  logic [NUM_WATCH-1:0]       arm,
  input  logic [NUM_WATCH-1:0]       clear,
  output logic [7:0]                 portc_o,
  output logic                       wr_evt_o,
  output logic [NUM_WATCH*CNT_W-1:0] cnt_o,
  output logic [NUM_WATCH-1:0]       done_o,
  output logic [NUM_WATCH-1:0]       busy_o
);

  typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_t;

  localparam int                TMR_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit                TMO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]  DONE_CNT = CNT_W'(DONE_COUNT);

  logic [7:0] portc_q, portc_d;
  logic       wr_evt_q, wr_evt_d;

  always_comb begin
    portc_d = portc_q;
    if (wr_stb) begin
      if (shavv == PPI_BASE + 8'd1) begin
        portc_d = data;
      end else if (shavv == PPI_BASE) begin
        if (!data[7]) begin
          portc_d[data[3:1]] = data[0];
        end
`ifdef PPI_MODESET_EN
        else begin
          portc_d = 8'h00;
        end
`endif
      end
    end
    wr_evt_d = (portc_d != portc_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      portc_q  <= PORTC_INIT;
      wr_evt_q <= 1'b0;
    end else begin
      portc_q  <= portc_d;
      wr_evt_q <= wr_evt_d;
    end
  end

  assign portc_o  = portc_q;
  assign wr_evt_o = wr_evt_q;

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_ch
    localparam logic [2:0] BIT = WATCH_MAP[3*g +: 3];
    localparam bit         POL = EDGE_POL[g];

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             edge_hit;

    // portc_d equals portc_q except on a write, so this sees only old-vs-new per host write
    assign edge_hit = POL ? (~portc_q[BIT] &  portc_d[BIT])
                          : ( portc_q[BIT] & ~portc_d[BIT]);

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      tmr_d = '0;
      if (clear[g]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (arm[g]) begin
        st_d  = COUNTING;
        cnt_d = '0;
      end else if (st_q == COUNTING) begin
        if (edge_hit) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == DONE_CNT) st_d = DONE;
        end else if (TMO_EN && (tmr_q == TMR_LAST)) begin
          cnt_d = '0;
        end else if (TMO_EN) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        tmr_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        tmr_q <= tmr_d;
      end
    end

    assign cnt_o[g*CNT_W +: CNT_W] = cnt_q;
    assign done_o[g] = (st_q == DONE);
    assign busy_o[g] = (st_q == COUNTING);
  end

endmodule
